// File: rtl/mmss_bcd_timer.sv
// mm:ss BCD timer: counts down from a preset to 00:00 or up to 59:59 on a
// prescaled one-second tick and drives the four-digit seven-segment decoder.
module mmss_bcd_timer #(
    parameter int TICKS_PER_SECOND = 50000000,
    parameter int PRESCALE_WIDTH   = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] preset_minute_tens,
    input  logic [3:0] preset_minute_unit,
    input  logic [3:0] preset_second_tens,
    input  logic [3:0] preset_second_unit,
    input  logic       count_up,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] minute_tens,
    output logic [3:0] minute_unit,
    output logic [3:0] second_tens,
    output logic [3:0] second_unit,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(TICKS_PER_SECOND - 1);
    localparam logic [15:0] TIME_ZERO = 16'h0000;
    localparam logic [15:0] TIME_MAX  = 16'h5959;

    // Time is kept packed as {minute_tens, minute_unit, second_tens, second_unit}.
    function automatic logic [15:0] step_down(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    mt = (mt != 4'd0) ? mt - 4'd1 : 4'd0;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    function automatic logic [15:0] step_up(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd9) begin
            su = su + 4'd1;
        end else begin
            su = 4'd0;
            if (st != 4'd5) begin
                st = st + 4'd1;
            end else begin
                st = 4'd0;
                if (mu != 4'd9) begin
                    mu = mu + 4'd1;
                end else begin
                    mu = 4'd0;
                    mt = (mt != 4'd5) ? mt + 4'd1 : 4'd5;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    function automatic logic preset_is_valid(input logic [15:0] t);
        return (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    state_t                    state_q, state_d;
    logic [15:0]               time_q, time_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      up_q, up_d;
    logic                      done_q, done_d;
    logic                      load_err_q, load_err_d;

    logic [15:0] preset_time;
    logic [15:0] stepped_time;
    logic        start_blocked;

    assign preset_time   = {preset_minute_tens, preset_minute_unit,
                            preset_second_tens, preset_second_unit};
    assign stepped_time  = up_q ? step_up(time_q) : step_down(time_q);
    assign start_blocked = count_up ? (time_q == TIME_MAX) : (time_q == TIME_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            time_q     <= TIME_ZERO;
            presc_q    <= '0;
            up_q       <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            up_q       <= up_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // Control priority: clear, then load, then pause, then start, then counting.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        up_d       = up_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            time_d  = TIME_ZERO;
            presc_d = '0;
        end else if (load && (state_q != RUN)) begin
            if (!preset_is_valid(preset_time)) begin
                load_err_d = 1'b1;
            end else begin
                time_d  = preset_time;
                presc_d = '0;
                state_d = IDLE;
            end
        end else if (pause) begin
            if (state_q == RUN) begin
                state_d = PAUSED;
            end
        end else if (start && ((state_q == IDLE) || (state_q == PAUSED)) && !start_blocked) begin
            up_d    = count_up;
            state_d = RUN;
            if (state_q == IDLE) begin
                presc_d = '0;
            end
        end else if (state_q == RUN) begin
            if (presc_q == PRESCALE_LAST) begin
                presc_d = '0;
                time_d  = stepped_time;
                if (stepped_time == (up_q ? TIME_MAX : TIME_ZERO)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    assign {minute_tens, minute_unit, second_tens, second_unit} = time_q;
    assign running  = (state_q == RUN);
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mmss_bcd_timer.sv
// Scoreboard bench for mmss_bcd_timer with a four-cycle second: directed
// stimulus queues expected snapshots and done-pulse cycles for the monitor.
module tb_mmss_bcd_timer;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic [3:0] preset_minute_tens;
    logic [3:0] preset_minute_unit;
    logic [3:0] preset_second_tens;
    logic [3:0] preset_second_unit;
    logic       count_up;
    logic       start;
    logic       pause;
    logic [3:0] minute_tens;
    logic [3:0] minute_unit;
    logic [3:0] second_tens;
    logic [3:0] second_unit;
    logic       running;
    logic       done;
    logic       load_err;

    mmss_bcd_timer #(
        .TICKS_PER_SECOND(4),
        .PRESCALE_WIDTH  (3)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear             (clear),
        .load              (load),
        .preset_minute_tens(preset_minute_tens),
        .preset_minute_unit(preset_minute_unit),
        .preset_second_tens(preset_second_tens),
        .preset_second_unit(preset_second_unit),
        .count_up          (count_up),
        .start             (start),
        .pause             (pause),
        .minute_tens       (minute_tens),
        .minute_unit       (minute_unit),
        .second_tens       (second_tens),
        .second_unit       (second_unit),
        .running           (running),
        .done              (done),
        .load_err          (load_err)
    );

    typedef struct {
        int          cyc;
        logic [15:0] t;
        logic        run;
        logic        dn;
        logic        le;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;
    logic [15:0] mon_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mon_t = {minute_tens, minute_unit, second_tens, second_unit};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.cyc != cyc || mon_t !== mon_e.t || running !== mon_e.run ||
                done !== mon_e.dn || load_err !== mon_e.le) begin
                errors++;
                $display("FAIL %s: cyc=%0d time=%h running=%b done=%b load_err=%b, expected cyc=%0d time=%h running=%b done=%b load_err=%b",
                         mon_e.name, cyc, mon_t, running, done, load_err,
                         mon_e.cyc, mon_e.t, mon_e.run, mon_e.dn, mon_e.le);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_pulse: unexpected done at cyc=%0d", cyc);
            end else if (done_q[0] != cyc) begin
                errors++;
                $display("FAIL done_pulse: done at cyc=%0d, expected cyc=%0d", cyc, done_q[0]);
                void'(done_q.pop_front());
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic want(input int d, input logic [15:0] t, input logic r,
                        input logic dn, input logic le, input string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.t    = t;
        e.run  = r;
        e.dn   = dn;
        e.le   = le;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic set_preset(input logic [3:0] mt, input logic [3:0] mu,
                              input logic [3:0] st, input logic [3:0] su);
        preset_minute_tens = mt;
        preset_minute_unit = mu;
        preset_second_tens = st;
        preset_second_unit = su;
    endtask

    task automatic do_load(input logic [3:0] mt, input logic [3:0] mu,
                           input logic [3:0] st, input logic [3:0] su);
        set_preset(mt, mu, st, su);
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    task automatic do_start(input logic up);
        count_up = up;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        count_up = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        set_preset(4'd0, 4'd0, 4'd0, 4'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_init");

        do_load(4'd0, 4'd1, 4'd0, 4'd2);
        want(0, 16'h0102, 1'b0, 1'b0, 1'b0, "load_0102");
        start = 1'b1;
        pause = 1'b1;
        tick(1);
        start = 1'b0;
        pause = 1'b0;
        want(0, 16'h0102, 1'b0, 1'b0, 1'b0, "start_pause_idle");
        want(3, 16'h0102, 1'b0, 1'b0, 1'b0, "idle_hold");
        tick(3);

        // Countdown 01:02 -> 00:00 takes 62 seconds of four cycles each.
        do_start(1'b0);
        want(0,   16'h0102, 1'b1, 1'b0, 1'b0, "cd_start");
        want(3,   16'h0102, 1'b1, 1'b0, 1'b0, "cd_pre_tick");
        want(4,   16'h0101, 1'b1, 1'b0, 1'b0, "cd_0101");
        want(8,   16'h0100, 1'b1, 1'b0, 1'b0, "cd_0100");
        want(12,  16'h0059, 1'b1, 1'b0, 1'b0, "cd_0059");
        want(247, 16'h0001, 1'b1, 1'b0, 1'b0, "cd_0001");
        want(248, 16'h0000, 1'b0, 1'b1, 1'b0, "cd_done");
        want(249, 16'h0000, 1'b0, 1'b0, 1'b0, "cd_done_single");
        done_q.push_back(cyc + 248);
        tick(250);
        do_start(1'b0);
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "start_in_done");
        want(4, 16'h0000, 1'b0, 1'b0, 1'b0, "done_hold");
        tick(4);

        do_load(4'd0, 4'd1, 4'd0, 4'd2);
        want(0, 16'h0102, 1'b0, 1'b0, 1'b0, "load_from_done");
        do_load(4'd0, 4'd7, 4'd6, 4'd0);
        want(0, 16'h0102, 1'b0, 1'b0, 1'b1, "load_err_pulse");
        want(1, 16'h0102, 1'b0, 1'b0, 1'b0, "load_err_single");
        tick(1);

        // Pause lands while the prescaler holds 2, so resume steps after 2 cycles.
        do_start(1'b0);
        tick(6);
        do_pause();
        want(0,  16'h0101, 1'b0, 1'b0, 1'b0, "paused");
        want(10, 16'h0101, 1'b0, 1'b0, 1'b0, "paused_mid");
        want(20, 16'h0101, 1'b0, 1'b0, 1'b0, "paused_hold");
        tick(20);
        do_start(1'b0);
        want(0, 16'h0101, 1'b1, 1'b0, 1'b0, "resume");
        want(1, 16'h0101, 1'b1, 1'b0, 1'b0, "resume_wait");
        want(2, 16'h0100, 1'b1, 1'b0, 1'b0, "resume_step");
        tick(3);
        do_load(4'd0, 4'd0, 4'd0, 4'd5);
        want(0, 16'h0100, 1'b1, 1'b0, 1'b0, "load_in_run");
        want(2, 16'h0059, 1'b1, 1'b0, 1'b0, "run_after_load");
        tick(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "reset_mid_run");
        tick(1);
        do_start(1'b0);
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "start_reject_zero");

        do_load(4'd5, 4'd9, 4'd5, 4'd8);
        want(0, 16'h5958, 1'b0, 1'b0, 1'b0, "load_5958");
        do_start(1'b1);
        want(0, 16'h5958, 1'b1, 1'b0, 1'b0, "up_start");
        want(4, 16'h5959, 1'b0, 1'b1, 1'b0, "up_done");
        done_q.push_back(cyc + 4);
        tick(5);
        do_start(1'b1);
        want(0, 16'h5959, 1'b0, 1'b0, 1'b0, "start_in_done_up");
        do_load(4'd5, 4'd9, 4'd5, 4'd9);
        want(0, 16'h5959, 1'b0, 1'b0, 1'b0, "load_5959");
        do_start(1'b1);
        want(0, 16'h5959, 1'b0, 1'b0, 1'b0, "start_reject_max");
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "load_0000");
        do_start(1'b1);
        want(0, 16'h0000, 1'b1, 1'b0, 1'b0, "up_from_zero");
        want(4, 16'h0001, 1'b1, 1'b0, 1'b0, "up_0001");
        tick(4);
        do_clear();
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "clear_run");

        do_load(4'd0, 4'd9, 4'd5, 4'd9);
        do_start(1'b1);
        want(4, 16'h1000, 1'b1, 1'b0, 1'b0, "up_carry");
        tick(4);
        do_clear();
        set_preset(4'd0, 4'd1, 4'd2, 4'd3);
        clear = 1'b1;
        load  = 1'b1;
        tick(1);
        clear = 1'b0;
        load  = 1'b0;
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "clear_load");

        do_load(4'd1, 4'd0, 4'd0, 4'd0);
        do_start(1'b0);
        want(4, 16'h0959, 1'b1, 1'b0, 1'b0, "down_borrow");
        tick(4);
        do_clear();

        do_load(4'd0, 4'd0, 4'd0, 4'd1);
        do_start(1'b0);
        tick(3);
        do_clear();
        want(0, 16'h0000, 1'b0, 1'b0, 1'b0, "clear_on_tick");
        want(1, 16'h0000, 1'b0, 1'b0, 1'b0, "clear_on_tick_after");
        tick(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_drain: %0d expectations left, expected 0", exp_q.size());
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL done_drain: %0d done pulses missing, expected 0", done_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
